// File: rtl/student_bitscan16.sv
// rtl/student_bitscan16.sv - expands a 16-bit word into one output beat per set bit
//
// Purpose:
//   Accepts a 16-bit word when idle and emits one beat per set bit carrying that
//   bit's index. An all-zero word yields a single beat flagged out_none. One word
//   is processed at a time; input is back-pressured while a word is being emitted.
//
// Ports:
//   clk       in   1   clock, all state updates on rising edge
//   reset_n   in   1   synchronous active-low reset
//   in_word   in  16   word to expand
//   in_valid  in   1   in_word valid
//   in_ready  out  1   block can accept a word (IDLE)
//   out_idx   out  4   index of the bit reported by the current beat
//   out_none  out  1   current beat reports an all-zero word (out_idx = 0)
//   out_last  out  1   current beat is the final beat of the word
//   out_valid out  1   beat outputs valid (SCAN)
//   out_ready in   1   consumer accepts the current beat
//
// Configuration:
//   STUDENT_BITSCAN_MSB_FIRST_EN  when defined, bits are reported highest index
//                                 first; otherwise lowest index first.

module student_bitscan16 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  out_idx,
  output logic        out_none,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [15:0] pending_q, pending_d;

  logic [3:0]  sel_idx;
  logic        pending_zero;
  logic        pending_single;
  logic        scan;

  // Priority pick of the bit to report next. The loop direction decides which
  // set bit wins: the last assignment in iteration order takes effect.
  always_comb begin
    sel_idx = 4'd0;
`ifdef STUDENT_BITSCAN_MSB_FIRST_EN
    for (int i = 0; i < 16; i++) begin
      if (pending_q[i]) sel_idx = 4'(i);
    end
`else
    for (int i = 15; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = 4'(i);
    end
`endif
  end

  assign scan           = (state_q == ST_SCAN);
  assign pending_zero   = (pending_q == 16'h0000);
  // x & (x-1) clears the lowest set bit; zero result means at most one bit set.
  assign pending_single = !pending_zero && ((pending_q & (pending_q - 16'd1)) == 16'h0000);

  assign in_ready  = !scan;
  assign out_valid = scan;
  assign out_idx   = scan ? sel_idx : 4'd0;
  // Pending can only be zero in SCAN when the accepted word itself was zero,
  // since the last set bit always returns the block to IDLE.
  assign out_none  = scan && pending_zero;
  assign out_last  = scan && (pending_zero || pending_single);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          pending_d = in_word;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (out_ready) begin
          pending_d = pending_q & ~(16'h0001 << sel_idx);
          if (out_last) state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_student_bitscan16.sv
// tb/tb_student_bitscan16.sv - scoreboard bench for student_bitscan16

module tb_student_bitscan16;

  logic        clk;
  logic        reset_n;
  logic [15:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_idx;
  logic        out_none;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    logic [3:0] idx;
    logic       none;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests;
  int    n_fail;

  student_bitscan16 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_idx   (out_idx),
    .out_none  (out_none),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference expansion of a word into its expected beat sequence.
  function automatic void push_word(input logic [15:0] w);
    beat_t b;
    int    cnt;
    int    seen;
    if (w == 16'h0000) begin
      b.idx = 4'd0; b.none = 1'b1; b.last = 1'b1;
      exp_q.push_back(b);
      return;
    end
    cnt = $countones(w);
    seen = 0;
    for (int k = 0; k < 16; k++) begin
`ifdef STUDENT_BITSCAN_MSB_FIRST_EN
      int i = 15 - k;
`else
      int i = k;
`endif
      if (w[i]) begin
        seen++;
        b.idx = 4'(i); b.none = 1'b0; b.last = (seen == cnt);
        exp_q.push_back(b);
      end
    end
  endfunction

  // Monitor: inputs are driven #1 after posedge, so at negedge every handshake
  // signal is stable and describes what the coming edge will do.
  always @(negedge clk) begin
    beat_t e;
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) push_word(in_word);
      if (out_valid) chk("ready_low_in_scan", int'(in_ready), 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_beat", int'(out_idx), -1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_idx", int'(out_idx), int'(e.idx));
          chk("sb_none", int'(out_none), int'(e.none));
          chk("sb_last", int'(out_last), int'(e.last));
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_idx"}, int'(out_idx), 0);
    chk({tag, "_out_none"}, int'(out_none), 0);
    chk({tag, "_out_last"}, int'(out_last), 0);
  endtask

  // Send one word with out_ready held high; expect exp_beats consecutive valid
  // cycles starting the cycle after acceptance, then exactly one idle cycle.
  task automatic run_word(input string tag, input logic [15:0] w, input int exp_beats,
                          input bit release_reset);
    @(posedge clk); #1;
    if (release_reset) reset_n = 1'b1;
    in_word = w; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_accept"}, int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int b = 0; b < exp_beats; b++) begin
      @(negedge clk);
      chk({tag, "_beat_valid"}, int'(out_valid), 1);
    end
    @(negedge clk);
    chk({tag, "_idle_after"}, int'(in_ready), 1);
    chk({tag, "_no_extra_beat"}, int'(out_valid), 0);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    in_word   = 16'h0000;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");

    // First edge out of reset accepts a word.
    run_word("w0085", 16'h0085, 3, 1'b1);
    run_word("w0000", 16'h0000, 1, 1'b0);
    run_word("wffff", 16'hFFFF, 16, 1'b0);

    // Back-pressure: beat held, second word ignored while scanning.
    @(posedge clk); #1;
    in_word = 16'h8001; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    in_word = 16'h0010; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
`ifdef STUDENT_BITSCAN_MSB_FIRST_EN
      chk("hold_idx", int'(out_idx), 15);
`else
      chk("hold_idx", int'(out_idx), 0);
`endif
      chk("hold_last", int'(out_last), 0);
      if (c < 2) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("hold_idle_after", int'(in_ready), 1);
    chk("hold_sb_empty", exp_q.size(), 0);
    exp_q.delete();

    // Reset in the middle of a scan discards the word.
    @(posedge clk); #1;
    in_word = 16'h00F0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_first_beat_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check_idle("midscan_reset");
    run_word("w0002", 16'h0002, 1, 1'b1);

    repeat (3) @(negedge clk);
    chk("final_sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/student_bitscan16.md
STUDENT_BITSCAN16 -- requirements
Module: student_bitscan16

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n  input  1  synchronous active-low reset, sampled on rising clk edge.
REQ-003 SHALL have port in_word  input  16  vector to expand into set-bit indices.
REQ-004 SHALL have port in_valid  input  1  in_word valid this cycle.
REQ-005 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-006 SHALL have port out_idx  output  4  bit position of the current set bit.
REQ-007 SHALL have port out_none  output  1  current beat reports an all-zero word; out_idx=0.
REQ-008 SHALL have port out_last  output  1  current beat is the final beat for this word.
REQ-009 SHALL have port out_valid  output  1  out_idx/out_none/out_last valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the current beat.

Function
REQ-011 SHALL be the expanding inverse of an 8/16-way OR: one input word in, one output beat per set bit out.
REQ-012 SHALL implement two states: IDLE (in_ready=1, out_valid=0) and SCAN (in_ready=0, out_valid=1).
REQ-013 SHALL, in IDLE with in_valid=1 at an edge, latch in_word into a 16-bit pending register and enter SCAN; in_valid=0 holds IDLE.
REQ-014 SHALL present the first beat in the cycle after acceptance (latency 1 cycle).
REQ-015 SHALL, in SCAN, drive out_idx with the index of the lowest set bit of pending (LSB-first), combinationally from registered state.
REQ-016 SHALL drive out_last=1 when pending has exactly one set bit, or when pending is zero.
REQ-017 SHALL, on an edge with out_valid=1 and out_ready=1, clear the reported bit in pending; if out_last=1, return to IDLE.
REQ-018 SHALL hold out_idx, out_none, out_last and pending stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, for an accepted all-zero word, emit exactly one beat with out_none=1, out_last=1, out_idx=0.
REQ-020 SHALL ignore in_valid and in_word in SCAN; no second word is buffered.
REQ-021 SHALL, with out_ready held at 1, emit popcount(word) beats (min 1) on consecutive cycles followed by exactly one IDLE cycle before the next acceptance.
REQ-022 SHALL handle bit 15 and bit 0 as ordinary positions; an all-ones word produces 16 beats, out_idx 0..15, out_last only on idx 15.

Reset
REQ-023 SHALL, when reset_n=0 at an edge, enter IDLE and clear pending regardless of state, including mid-SCAN; the in-progress word is discarded.
REQ-024 SHALL, during and after reset, drive in_ready=1, out_valid=0, out_idx=0, out_none=0, out_last=0.
REQ-025 SHALL accept a word on the first edge with reset_n=1 and in_valid=1.

Configuration
REQ-026 SHALL, when macro STUDENT_BITSCAN_MSB_FIRST_EN is defined, report set bits highest-index first (out_idx = highest set bit; out_last on the lowest set bit).
REQ-027 SHALL, without STUDENT_BITSCAN_MSB_FIRST_EN, use LSB-first ordering per REQ-015; ports, latency and zero-word behaviour are identical in both builds.

Verification
REQ-028 SHALL cover: reset, in_word=16'h0085, in_valid=1 one cycle, out_ready=1 -> beats idx 0,2,7; out_last only on 7; in_ready=1 the cycle after the idx-7 beat.
REQ-029 SHALL cover: in_word=16'h0000 accepted -> single beat out_none=1, out_last=1, out_idx=0; then IDLE.
REQ-030 SHALL cover: in_word=16'hFFFF, out_ready=1 -> 16 consecutive beats idx 0..15, exactly 16 valid cycles.
REQ-031 SHALL cover: in_word=16'h8001, out_ready=0 for 3 cycles -> idx 0 held stable with out_valid=1; a second in_valid with 16'h0010 during SCAN is ignored; release -> idx 0, 15 only.
REQ-032 SHALL cover: reset_n=0 asserted after the first beat of 16'h00F0 -> next cycle IDLE, out_valid=0; new word 16'h0002 -> single beat idx 1, out_last=1.
REQ-033 SHALL cover, with STUDENT_BITSCAN_MSB_FIRST_EN defined: in_word=16'h0085 -> beats idx 7,2,0; out_last on 0.
